// File: rtl/muxdff_chain_ctrl.sv
// Load/shift sequencer for a chain of mux-D flip-flops.
// Accepts a parallel word, then streams it out LSB-first under shift_en.
module muxdff_chain_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             cell_L,
    output logic [WIDTH-1:0] chain_q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              shift;
    logic [WIDTH-1:0]  q_in;
    logic [WIDTH-1:0]  chain_d;

    // Control outputs are forced low while reset is asserted.
    assign load_ready   = (state == IDLE) && !reset;
    assign accept       = load_valid && load_ready;
    assign cell_L       = accept;
    assign shift        = (state == SHIFT) && shift_en && !reset;
    assign serial_valid = shift;
    assign serial_out   = chain_q[0];
    assign busy         = (state != IDLE) && !reset;
    assign done         = (state == DONE) && !reset;

    // Each cell: Q <= L ? r_in : q_in, top cell fed with zero.
    always_comb begin
        q_in    = {1'b0, chain_q[WIDTH-1:1]};
        chain_d = cell_L ? load_data : q_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            chain_q <= '0;
            cnt     <= '0;
        end else begin
            if (cell_L || shift)
                chain_q <= chain_d;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muxdff_chain_ctrl.sv
// Directed bench with a serial-bit scoreboard for muxdff_chain_ctrl.
module tb_muxdff_chain_ctrl;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_data;
    logic       shift_en;
    logic       serial_out;
    logic       serial_valid;
    logic       cell_L;
    logic [3:0] chain_q;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;
    bit exp_q[$];

    muxdff_chain_ctrl #(.WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .shift_en(shift_en),
        .serial_out(serial_out),
        .serial_valid(serial_valid),
        .cell_L(cell_L),
        .chain_q(chain_q),
        .busy(busy),
        .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    endtask

    // Falling edge: pop/compare any valid serial bit.
    task automatic half();
        @(negedge clk);
        if (serial_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_bit", 32'(serial_valid), 32'd0);
            end else begin
                chk("sb_bit", 32'(serial_out), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic clk1();
        half();
        adv();
    endtask

    logic [5:0] pat;
    int acc0;
    int acc1;
    int nacc;

    initial begin
        reset = 1; load_valid = 0; load_data = 0; shift_en = 0;
        // 1: reset
        adv();
        half();
        chk("rst_ready", 32'(load_ready), 32'd0);
        adv();
        half();
        chk("rst_chain", 32'(chain_q), 32'd0);
        chk("rst_ready2", 32'(load_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cellL", 32'(cell_L), 32'd0);
        adv();
        reset = 0;
        half();
        chk("idle_ready", 32'(load_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        adv();

        // 2: load and shift 1011
        load_valid = 1; load_data = 4'b1011; shift_en = 1;
        push_word(4'b1011);
        half();
        chk("t2_cellL_acc", 32'(cell_L), 32'd1);
        adv();
        load_valid = 0;
        for (int i = 0; i < 4; i++) begin
            half();
            chk("t2_valid", 32'(serial_valid), 32'd1);
            chk("t2_cellL", 32'(cell_L), 32'd0);
            chk("t2_busy", 32'(busy), 32'd1);
            adv();
        end
        half();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_done_sv", 32'(serial_valid), 32'd0);
        chk("t2_done_chain", 32'(chain_q), 32'd0);
        chk("t2_done_ready", 32'(load_ready), 32'd0);
        adv();
        half();
        chk("t2_ready", 32'(load_ready), 32'd1);
        chk("t2_done_off", 32'(done), 32'd0);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
        adv();

        // 3: stall
        load_valid = 1; load_data = 4'b0110;
        push_word(4'b0110);
        clk1();
        load_valid = 0;
        pat = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            shift_en = pat[i];
            half();
            if (!shift_en) begin
                chk("t3_stall_sv", 32'(serial_valid), 32'd0);
                chk("t3_stall_q", 32'(chain_q), 32'b0011);
            end
            chk("t3_no_done", 32'(done), 32'd0);
            adv();
        end
        half();
        chk("t3_done", 32'(done), 32'd1);
        adv();
        clk1();
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: load_valid ignored while busy
        shift_en = 1;
        load_valid = 1; load_data = 4'b1000;
        push_word(4'b1000);
        clk1();
        load_data = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            half();
            chk("t4_ready", 32'(load_ready), 32'd0);
            chk("t4_cellL", 32'(cell_L), 32'd0);
            adv();
        end
        half();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_done_cellL", 32'(cell_L), 32'd0);
        adv();
        half();
        chk("t4_accept", 32'(cell_L), 32'd1);
        push_word(4'b1111);
        adv();
        load_valid = 0;
        for (int i = 0; i < 5; i++) clk1();
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
        clk1();

        // 5: reset mid-shift
        load_valid = 1; load_data = 4'b1101;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        clk1();
        load_valid = 0;
        clk1();
        clk1();
        reset = 1; shift_en = 0;
        half();
        chk("t5_rst_ready", 32'(load_ready), 32'd0);
        adv();
        reset = 0;
        half();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_chain", 32'(chain_q), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_ready", 32'(load_ready), 32'd1);
        adv();
        half();
        chk("t5_done2", 32'(done), 32'd0);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        adv();

        // 6: back-to-back words
        load_valid = 1; shift_en = 1; load_data = 4'b0101;
        acc0 = -1; acc1 = -1; nacc = 0;
        for (int i = 0; i < 12; i++) begin
            half();
            if (cell_L === 1'b1) begin
                push_word(load_data);
                if (nacc == 0) acc0 = cycle;
                else acc1 = cycle;
                nacc++;
            end
            adv();
            if (nacc == 1) load_data = 4'b1010;
            if (nacc == 2) load_valid = 0;
        end
        chk("t6_naccept", 32'(nacc), 32'd2);
        chk("t6_spacing", 32'(acc1 - acc0), 32'd6);
        for (int i = 0; i < 6; i++) clk1();
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muxdff_chain_ctrl.md
Name: muxdff_chain_ctrl

Overview:
Sequencer for a WIDTH-cell chain of mux-D flip-flops. Each cell is Q <= L ? r_in : q_in: L selects a parallel load from r_in, otherwise the cell takes q_in from its upstream neighbour. The block owns the chain and its shared L select. It accepts a parallel word over a valid/ready handshake, loads it in one cycle, then shifts it out serially LSB-first under an enable, and pulses done when finished. It sits between a word producer and a bit-serial consumer.

Parameters:
WIDTH, 4, number of mux-DFF cells in the chain (>= 2)
CNT_W, $clog2(WIDTH), width of the shift counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load_valid  input  1  producer offers load_data
load_ready  output  1  block can accept a word
load_data  input  WIDTH  parallel word; drives r_in of cell i from bit i
shift_en  input  1  consumer takes a bit this cycle; 0 stalls the shift
serial_out  output  1  current chain LSB, chain_q[0]
serial_valid  output  1  serial_out is a valid data bit this cycle
cell_L  output  1  shared L select driven to every cell
chain_q  output  WIDTH  chain contents, for observability
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse after the last bit shifts

Behaviour:
- Chain:
  - Cell i has r_in = load_data[i].
  - Cell i has q_in = chain_q[i+1]; the top cell's q_in is 1'b0.
  - Cells update only when cell_L=1 or a shift occurs; otherwise they hold.
- Reset (sync, dominant over all inputs):
  - state=IDLE, chain_q=0, cnt=0.
  - load_ready=0 during the reset cycle, and 1 from the first cycle after reset deasserts.
  - All other outputs are 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, busy=0, serial_valid=0.
  - Accept = load_valid & load_ready.
  - cell_L = accept (combinational). On that edge: chain_q <= load_data, cnt <= 0, state -> SHIFT.
  - If no accept, the chain holds.
- SHIFT:
  - load_ready=0, cell_L=0, busy=1.
  - serial_valid = shift_en; serial_out = chain_q[0].
  - On an edge with shift_en=1: chain shifts right one place, zero-filled at the top, and cnt <= cnt+1.
  - If cnt==WIDTH-1 on such an edge, state -> DONE.
  - On an edge with shift_en=0: chain and cnt hold (stall of any length).
  - load_valid is ignored in SHIFT.
- DONE:
  - done=1, busy=1, load_ready=0, serial_valid=0, chain_q=0.
  - Unconditionally -> IDLE next cycle.
  - load_valid is ignored in DONE.
- Timing:
  - Latency from accept edge to first valid bit: 0 cycles; serial_valid can be high in the first SHIFT cycle.
  - Minimum word period with shift_en held high: 1 (accept) + WIDTH (shift) + 1 (DONE) = WIDTH+2 cycles.
  - Next accept is possible in the cycle after DONE.
- Reset mid-operation (SHIFT or DONE): abort to IDLE with chain cleared; no done pulse.
- Simultaneous reset and load_valid: reset wins, no load.
- Counter: cnt is CNT_W bits, never exceeds WIDTH-1, and does not wrap within a word.

Test Plan:
1. Reset then idle, WIDTH=4: reset=1 for 2 cycles -> chain_q=4'b0000, load_ready=0 during reset and 1 in the cycle after, busy=0, done=0, cell_L=0.
2. Load and shift: load_valid=1, load_data=4'b1011, shift_en held 1 -> cell_L=1 for exactly the accept cycle; serial_out=1,1,0,1 with serial_valid=1 on 4 consecutive cycles; done=1 on the next cycle; load_ready=1 one cycle later.
3. Stall: load 4'b0110, shift_en pattern 1,0,0,1,1,1 -> bits 0,1,1,0 appear only on shift_en=1 cycles; chain_q holds 4'b0011 during the stall; done follows the 4th shifted bit.
4. Ignore during busy: hold load_valid=1 with load_data=4'b1111 through SHIFT and DONE of word 4'b1000 -> output bits 0,0,0,1; then 4'b1111 is accepted in the first IDLE cycle after DONE.
5. Reset mid-shift: load 4'b1101, shift 2 bits, assert reset -> next cycle state IDLE, chain_q=0, no done pulse, load_ready=1 once reset drops.
6. Back-to-back words 4'b0101 then 4'b1010 with load_valid and shift_en held 1 -> serial bits 1,0,1,0 then 0,1,0,1; accepts spaced exactly 6 cycles apart.
